fifo_burst_reader: RTL and testbench

//  Pop-side controller for the 32-bit x 4096 FIFO. Drains stored words in bursts
//  and presents them on a valid/ready stream with a last-word marker.
//  It hides the FIFO's one-cycle registered read latency behind a 2-entry skid buffer,
//  so a consumer that is always ready gets one word per cycle.

---
 rtl/fifo_burst_reader.sv | 204 ++++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Pop-side controller for a registered-output FIFO. Waits for
//                a full burst (or a flush request), pops the burst words, and
//                presents them on a valid/ready stream with a last-word
//                marker. A 2-entry skid buffer absorbs the FIFO's one-cycle
//                read latency so an always-ready consumer receives one word
//                per cycle.
//  Ports       :
//    clk           in   system clock, rising edge
//    rst_n         in   asynchronous reset, active low
//    fifo_rd_en    out  FIFO pop request (combinational)
//    fifo_rd_data  in   FIFO registered read data, valid the cycle after rd_en
//    fifo_empty    in   FIFO empty flag
//    fifo_count    in   FIFO occupancy
//    flush         in   single-cycle request to drain a partial burst
//    m_valid       out  stream word valid
//    m_data        out  stream word
//    m_last        out  final word of the burst
//    m_ready       in   consumer accept
//    busy          out  high whenever the controller is not idle
//    burst_done    out  one-cycle pulse when a burst completes
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_WIDTH = 12,
  parameter int BURST_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 fifo_rd_en,
  input  logic [BIT_WIDTH-1:0] fifo_rd_data,
  input  logic                 fifo_empty,
  input  logic [CNT_WIDTH:0]   fifo_count,
  input  logic                 flush,
  output logic                 m_valid,
  output logic [BIT_WIDTH-1:0] m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 burst_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH:0] c_burst_len = BURST_LEN[CNT_WIDTH:0];
  localparam logic [CNT_WIDTH:0] c_one       = {{CNT_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [CNT_WIDTH:0]    r_len;
  logic [CNT_WIDTH:0]    r_issued;
  logic                  r_flush_pending;

  // Read pipeline: one word in flight between rd_en and the FIFO's data output.
  logic                  r_inflight;
  logic                  r_inflight_last;

  // Second skid entry; the head entry is the registered stream output itself.
  logic                  r_sk_valid;
  logic [BIT_WIDTH-1:0]  r_sk_data;
  logic                  r_sk_last;

  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [2:0]            w_level;
  logic                  w_rd_en;
  logic                  w_issue_last;
  logic [CNT_WIDTH:0]    w_flush_len;

  assign w_pop   = m_valid & m_ready;
  assign w_occ   = {1'b0, m_valid} + {1'b0, r_sk_valid};

  // Occupancy the skid buffer will have after this edge, excluding any word
  // issued now. Issuing only when this is below 2 guarantees a free slot
  // when the issued word arrives.
  assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_issue_last = (r_issued == (r_len - c_one));

  assign w_rd_en = (r_state == ST_RUN) && !fifo_empty &&
                   (r_issued < r_len) && (w_level < 3'd2);

  assign fifo_rd_en = w_rd_en;

  assign w_flush_len = (fifo_count > c_burst_len) ? c_burst_len : fifo_count;

  // --------------------------------------------------------------------------
  // Burst control state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_issued        <= '0;
      r_flush_pending <= 1'b0;
      busy            <= 1'b0;
      burst_done      <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fifo_count >= c_burst_len) begin
            r_state         <= ST_RUN;
            busy            <= 1'b1;
            r_len           <= c_burst_len;
            r_issued        <= '0;
            r_flush_pending <= 1'b0;
          end else if (r_flush_pending && !fifo_empty) begin
            r_state         <= ST_RUN;
            busy            <= 1'b1;
            r_len           <= w_flush_len;
            r_issued        <= '0;
            r_flush_pending <= 1'b0;
          end else if (fifo_empty) begin
            // Nothing to drain: a pending flush is satisfied.
            r_flush_pending <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_rd_en) begin
            r_issued <= r_issued + c_one;
            if (w_issue_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_inflight && (w_occ == 2'd0)) begin
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
            burst_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
      // A new flush request wins over a same-cycle clear so it is never lost.
      if (flush) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline and 2-entry skid buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_sk_valid      <= 1'b0;
      r_sk_data       <= '0;
      r_sk_last       <= 1'b0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_last          <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      // Words return in issue order, so the last tag is decided at issue.
      if (w_rd_en) begin
        r_inflight_last <= w_issue_last;
      end

      if (w_pop) begin
        if (r_sk_valid) begin
          m_data <= r_sk_data;
          m_last <= r_sk_last;
          if (r_inflight) begin
            r_sk_data <= fifo_rd_data;
            r_sk_last <= r_inflight_last;
          end else begin
            r_sk_valid <= 1'b0;
          end
        end else if (r_inflight) begin
          m_data <= fifo_rd_data;
          m_last <= r_inflight_last;
        end else begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end else if (r_inflight) begin
        if (!m_valid) begin
          m_valid <= 1'b1;
          m_data  <= fifo_rd_data;
          m_last  <= r_inflight_last;
        end else begin
          r_sk_valid <= 1'b1;
          r_sk_data  <= fifo_rd_data;
          r_sk_last  <= r_inflight_last;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Self-checking bench for fifo_burst_reader. A queue-based FIFO
//                model feeds the DUT; a scoreboard checks stream order, burst
//                boundaries, stall stability and burst completion counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

  localparam int BW = 32;
  localparam int CW = 12;
  localparam int BL = 16;

  typedef logic [CW:0] cnt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [BW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic [CW:0]   fifo_count;
  logic          flush = 1'b0;
  logic          m_valid;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          burst_done;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .BIT_WIDTH (BW),
    .CNT_WIDTH (CW),
    .BURST_LEN (BL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .busy         (busy),
    .burst_done   (burst_done)
  );

  // --------------------------------------------------------------------------
  // Checker
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // FIFO model: registered read data, occupancy updated after each edge
  // --------------------------------------------------------------------------
  logic [BW-1:0] fifo_q[$];
  logic          wr_req  = 1'b0;
  logic [BW-1:0] wr_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      fifo_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      if (wr_req) fifo_q.push_back(wr_data);
      fifo_count <= cnt_t'(fifo_q.size());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // --------------------------------------------------------------------------
  // Consumer ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random
  // --------------------------------------------------------------------------
  int ready_mode = 0;
  int rdy_idx    = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((rdy_idx % 3) == 0);
      default: m_ready = (($urandom % 4) != 0);
    endcase
    rdy_idx++;
  end

  // --------------------------------------------------------------------------
  // Scoreboard / monitor
  // --------------------------------------------------------------------------
  logic [BW-1:0] exp_q[$];    // every word written, in order
  int            exp_len[$];  // expected length of each upcoming burst
  int            pos         = 0;
  int            exp_bursts  = 0;
  int            done_cnt    = 0;
  int            hs_cnt      = 0;
  int            cyc         = 0;
  int            rd_run      = 0;
  int            max_run     = 0;
  int            first_rd    = -1;
  int            first_v     = -1;
  int            first_hs    = -1;
  int            last_hs     = -1;
  logic          prev_stall  = 1'b0;
  logic [BW:0]   prev_word   = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      chk_eq("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
      if (fifo_rd_en) begin
        rd_run++;
        if (rd_run > max_run) max_run = rd_run;
        if (first_rd < 0) first_rd = cyc;
      end else begin
        rd_run = 0;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        chk_eq("stall_valid", m_valid, 1);
        chk_eq("stall_word", {m_last, m_data}, prev_word);
      end
      if (burst_done) done_cnt++;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() == 0 || exp_len.size() == 0) begin
          chk_eq("unexpected_word", 1, 0);
        end else begin
          chk_eq("data", m_data, exp_q.pop_front());
          chk_eq("last", m_last, (pos == exp_len[0] - 1));
          pos++;
          if (pos == exp_len[0]) begin
            void'(exp_len.pop_front());
            pos = 0;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called at #1 after a rising edge)
  // --------------------------------------------------------------------------
  task automatic reset_stats();
    max_run  = 0;
    first_rd = -1;
    first_v  = -1;
    first_hs = -1;
    last_hs  = -1;
  endtask

  task automatic plan_full_bursts(input int n);
    for (int k = 0; k < n / BL; k++) begin
      exp_len.push_back(BL);
      exp_bursts++;
    end
  endtask

  task automatic write_words(input int n, input bit rnd, input logic [BW-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_data = rnd ? BW'($urandom) : base + BW'(i);
      wr_req  = 1'b1;
      exp_q.push_back(wr_data);
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
  endtask

  task automatic do_flush(input int len);
    if (len > 0) begin
      exp_len.push_back(len);
      exp_bursts++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 4 && n < 3000) begin
      @(negedge clk);
      if (!busy && !m_valid && !fifo_rd_en && !wr_req) q++;
      else q = 0;
      n++;
    end
    chk_eq({tag, "_settled"}, (q >= 4), 1);
    @(posedge clk); #1;
  endtask

  task automatic end_of_test(input string tag);
    chk_eq({tag, "_words_left"}, exp_q.size(), 0);
    chk_eq({tag, "_bursts_left"}, exp_len.size(), 0);
    chk_eq({tag, "_done_count"}, done_cnt, exp_bursts);
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int hs0;
    int w;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_m_valid", m_valid, 0);
    chk_eq("rst_m_data", m_data, 0);
    chk_eq("rst_m_last", m_last, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_burst_done", burst_done, 0);
    chk_eq("rst_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: one full burst with an always-ready consumer
    ready_mode = 0;
    reset_stats();
    plan_full_bursts(16);
    write_words(16, 1'b0, 32'd0);
    wait_quiet("t1");
    chk_eq("t1_rd_en_run", max_run, 16);
    chk_eq("t1_latency", first_v - first_rd, 2);
    chk_eq("t1_back_to_back", last_hs - first_hs, 15);
    end_of_test("t1");

    // 2: partial burst drained by flush
    write_words(5, 1'b0, 32'hA0);
    wait_quiet("t2_hold");
    chk_eq("t2_fifo_count", fifo_count, 5);
    do_flush(5);
    wait_quiet("t2");
    end_of_test("t2");

    // 3: consumer stalls in a 1,0,0 pattern
    ready_mode = 1;
    plan_full_bursts(16);
    write_words(16, 1'b1, 32'd0);
    wait_quiet("t3");
    end_of_test("t3");

    // 4: 40 words -> two full bursts, 8 left, flushed afterwards
    ready_mode = 0;
    plan_full_bursts(40);
    write_words(40, 1'b0, 32'h100);
    wait_quiet("t4_full");
    chk_eq("t4_fifo_left", fifo_count, 8);
    do_flush(8);
    wait_quiet("t4");
    end_of_test("t4");

    // 5: reset in the middle of a burst
    ready_mode = 0;
    plan_full_bursts(16);
    hs0 = hs_cnt;
    write_words(16, 1'b1, 32'd0);
    w = 0;
    while ((hs_cnt - hs0) < 7 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk_eq("t5_reached_word7", (hs_cnt - hs0) >= 7, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t5_m_valid", m_valid, 0);
    chk_eq("t5_m_data", m_data, 0);
    chk_eq("t5_m_last", m_last, 0);
    chk_eq("t5_busy", busy, 0);
    chk_eq("t5_burst_done", burst_done, 0);
    chk_eq("t5_rd_en", fifo_rd_en, 0);
    exp_bursts = exp_bursts - exp_len.size();
    exp_q.delete();
    exp_len.delete();
    pos        = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("t5_post_valid", m_valid, 0);
      chk_eq("t5_post_busy", busy, 0);
    end
    @(posedge clk); #1;
    end_of_test("t5");

    // 6: flush with an empty FIFO must not leave a pending request behind
    do_flush(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_eq("t6_busy_empty", busy, 0);
    end
    @(posedge clk); #1;
    write_words(3, 1'b1, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_eq("t6_no_stale_flush", busy, 0);
    end
    chk_eq("t6_fifo_count", fifo_count, 3);
    @(posedge clk); #1;
    do_flush(3);
    wait_quiet("t6");
    end_of_test("t6");

    // 7: random word counts, data and consumer back-pressure
    for (int it = 0; it < 4; it++) begin
      ready_mode = 2;
      n = $urandom_range(1, 40);
      plan_full_bursts(n);
      write_words(n, 1'b1, 32'd0);
      wait_quiet("rnd_full");
      chk_eq("rnd_fifo_left", fifo_count, n % BL);
      do_flush(n % BL);
      wait_quiet("rnd");
      end_of_test("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
